// File: rtl/ram_bus_pkg.sv
// Shared definitions for the single-port RAM bus: FSM encoding, idle strobe levels
// and RAM depth derivation, reused by the master, the RAM model and future arbiters.
package ram_bus_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_BEAT = 3'd1;
    localparam logic [2:0] ST_RD_ADDR = 3'd2;
    localparam logic [2:0] ST_RD_DATA = 3'd3;
    localparam logic [2:0] ST_TURN    = 3'd4;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        WR_BEAT = ST_WR_BEAT,
        RD_ADDR = ST_RD_ADDR,
        RD_DATA = ST_RD_DATA,
        TURN    = ST_TURN
    } bus_state_t;

    // Strobe levels presented whenever no beat is on the bus.
    localparam logic CS_IDLE = 1'b0;
    localparam logic OE_IDLE = 1'b0;
    localparam logic RW_IDLE = 1'b0;

    function automatic int ram_depth(input int addr_width);
        return 32'sd1 << addr_width;
    endfunction

endpackage

// File: rtl/ram_bus_tristate.sv
// Bus-side half of the shared RAM data bus: registered drive enable and data,
// released to Hi-Z whenever the master is not presenting a write beat.
module ram_bus_tristate #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  drive_en,
    input  logic [DATA_WIDTH-1:0] drive_data,
    inout  wire  [DATA_WIDTH-1:0] bus
);

    logic                  en_r;
    logic [DATA_WIDTH-1:0] data_r;

    // Capture the beat to drive; enable lines up with the registered cs/rw strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_r   <= 1'b0;
            data_r <= {DATA_WIDTH{1'b0}};
        end else begin
            en_r <= drive_en;
            if (drive_en) begin
                data_r <= drive_data;
            end else begin
                data_r <= {DATA_WIDTH{1'b0}};
            end
        end
    end

    assign bus = en_r ? data_r : {DATA_WIDTH{1'bz}};

endmodule

// File: rtl/ram_bus_master.sv
// Burst initiator for a single-port RAM: accepts read/write bursts on a valid/ready
// handshake and sequences registered addr/cs/oe/rw strobes with auto-incrementing address.
module ram_bus_master
    import ram_bus_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_rw,
    output logic                  ram_cs,
    output logic                  ram_oe
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LEN_WIDTH-1:0]  LEN_ZERO  = {LEN_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    bus_state_t            state_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [LEN_WIDTH-1:0]  cnt_r;
    logic                  req_ready_r;
    logic                  wr_ready_r;
    logic                  rd_valid_r;
    logic                  rd_last_r;
    logic [DATA_WIDTH-1:0] rd_data_r;
    logic                  busy_r;
    logic [ADDR_WIDTH-1:0] ram_addr_r;
    logic                  ram_rw_r;
    logic                  ram_cs_r;
    logic                  ram_oe_r;

    logic                  req_fire_s;
    logic                  wr_fire_s;
    logic                  last_beat_s;

    assign req_fire_s  = req_valid && req_ready_r && (state_r == IDLE);
    assign wr_fire_s   = wr_valid && wr_ready_r && (state_r == WR_BEAT);
    assign last_beat_s = (cnt_r == LEN_ZERO);

    // Command sequencing, beat counting and the registered bus strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            addr_r      <= ADDR_ZERO;
            cnt_r       <= LEN_ZERO;
            req_ready_r <= 1'b0;
            wr_ready_r  <= 1'b0;
            rd_valid_r  <= 1'b0;
            rd_last_r   <= 1'b0;
            rd_data_r   <= DATA_ZERO;
            busy_r      <= 1'b0;
            ram_addr_r  <= ADDR_ZERO;
            ram_rw_r    <= RW_IDLE;
            ram_cs_r    <= CS_IDLE;
            ram_oe_r    <= OE_IDLE;
        end else begin
            rd_valid_r <= 1'b0;
            rd_last_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    ram_rw_r <= RW_IDLE;
                    if (req_fire_s) begin
                        addr_r      <= req_addr;
                        cnt_r       <= req_len;
                        req_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        if (req_we) begin
                            state_r    <= WR_BEAT;
                            wr_ready_r <= 1'b1;
                            ram_cs_r   <= CS_IDLE;
                            ram_oe_r   <= OE_IDLE;
                        end else begin
                            // Read strobes go out with the address in the first read cycle.
                            state_r    <= RD_ADDR;
                            ram_addr_r <= req_addr;
                            ram_cs_r   <= 1'b1;
                            ram_oe_r   <= 1'b1;
                        end
                    end else begin
                        req_ready_r <= 1'b1;
                        ram_cs_r    <= CS_IDLE;
                        ram_oe_r    <= OE_IDLE;
                    end
                end
                WR_BEAT: begin
                    if (wr_fire_s) begin
                        ram_cs_r   <= 1'b1;
                        ram_rw_r   <= 1'b1;
                        ram_oe_r   <= 1'b0;
                        ram_addr_r <= addr_r;
                        addr_r     <= addr_r + ADDR_ONE;
                        if (last_beat_s) begin
                            state_r    <= TURN;
                            wr_ready_r <= 1'b0;
                        end else begin
                            cnt_r <= cnt_r - LEN_ONE;
                        end
                    end else begin
                        ram_cs_r <= CS_IDLE;
                        ram_rw_r <= RW_IDLE;
                        ram_oe_r <= OE_IDLE;
                    end
                end
                RD_ADDR: begin
                    state_r <= RD_DATA;
                end
                RD_DATA: begin
                    rd_valid_r <= 1'b1;
                    rd_data_r  <= ram_data;
                    rd_last_r  <= last_beat_s;
                    if (last_beat_s) begin
                        state_r  <= TURN;
                        ram_cs_r <= CS_IDLE;
                        ram_oe_r <= OE_IDLE;
                    end else begin
                        state_r    <= RD_ADDR;
                        addr_r     <= addr_r + ADDR_ONE;
                        ram_addr_r <= addr_r + ADDR_ONE;
                        cnt_r      <= cnt_r - LEN_ONE;
                    end
                end
                TURN: begin
                    // Dead cycle: nothing new is launched, bus released at the end.
                    state_r     <= IDLE;
                    busy_r      <= 1'b0;
                    req_ready_r <= 1'b1;
                    ram_cs_r    <= CS_IDLE;
                    ram_oe_r    <= OE_IDLE;
                    ram_rw_r    <= RW_IDLE;
                end
                default: begin
                    state_r     <= IDLE;
                    busy_r      <= 1'b0;
                    req_ready_r <= 1'b0;
                    wr_ready_r  <= 1'b0;
                    ram_cs_r    <= CS_IDLE;
                    ram_oe_r    <= OE_IDLE;
                    ram_rw_r    <= RW_IDLE;
                end
            endcase
        end
    end

    ram_bus_tristate #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_tristate (
        .clk        (clk),
        .rst_n      (rst_n),
        .drive_en   (wr_fire_s),
        .drive_data (wr_data),
        .bus        (ram_data)
    );

    assign req_ready = req_ready_r;
    assign wr_ready  = wr_ready_r;
    assign rd_valid  = rd_valid_r;
    assign rd_data   = rd_data_r;
    assign rd_last   = rd_last_r;
    assign busy      = busy_r;
    assign ram_addr  = ram_addr_r;
    assign ram_rw    = ram_rw_r;
    assign ram_cs    = ram_cs_r;
    assign ram_oe    = ram_oe_r;

endmodule
